// File: rtl/nrdiv_pkg.sv
// Purpose: shared types and sizing helpers for the non-restoring divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package nrdiv_pkg;

    // Divider sequencing: accept, M add/sub iterations, remainder fix-up, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter width for an m-bit divider.
    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nrdiv_if.sv
// Purpose: operand/result handshake bundle between a producer/consumer and the divider.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Modports: master = producer/consumer side, slave = divider side.
interface nrdiv_if #(
    parameter int M = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] dividend;
    logic [M-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] quotient;
    logic [M-1:0] remainder;
    logic         dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz
    );
endinterface

// File: rtl/nrdiv_addsub.sv
// Purpose: W-bit two's-complement adder/subtractor (sum = a + b, or a - b when sub=1).
// Latency: combinational.
// Backpressure: none.
// Ports: sub selects subtract, a/b operands, sum result (carry-out dropped).
module nrdiv_addsub #(
    parameter int W = 33
) (
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    // Subtract as a + ~b + 1: invert b and feed sub in as the carry.
    assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/non_restoring_divider.sv
// Purpose: sequential unsigned M-bit divider, non-restoring, one add/sub per clock.
// Latency: accept -> out_valid seen M+2 clocks later (1 clock with NRDIV_DZ_SHORTCUT_EN and divisor 0).
// Backpressure: one division in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (nrdiv_if.slave).
// Option: define NRDIV_DZ_SHORTCUT_EN to detect divisor 0 at accept and raise dz.
module non_restoring_divider
    import nrdiv_pkg::*;
#(
    parameter int M = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    nrdiv_if.slave bus
);
    localparam int CW = cnt_width(M);

    state_t         state;
    logic [M:0]     p;          // signed partial remainder
    logic [M-1:0]   a_reg;      // dividend shifting out, quotient bits shifting in
    logic [M-1:0]   d_reg;
    logic [CW-1:0]  count;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [M-1:0]   quo_q;
    logic [M-1:0]   rem_q;

    logic [M:0]     p_shift;
    logic [M:0]     as_a;
    logic [M:0]     as_sum;
    logic [M:0]     p_fixed;
    logic           as_sub;

    // {P,A} shifted left by one: next dividend bit enters P's LSB.
    assign p_shift = {p[M-1:0], a_reg[M-1]};

    // One adder serves both phases: CALC steers add/sub by P's sign,
    // FIX only ever adds D back to a negative remainder.
    always_comb begin
        as_sub = 1'b0;
        as_a   = p;
        if (state == CALC) begin
            as_sub = ~p[M];
            as_a   = p_shift;
        end
    end

    nrdiv_addsub #(.W(M + 1)) u_addsub (
        .sub (as_sub),
        .a   (as_a),
        .b   ({1'b0, d_reg}),
        .sum (as_sum)
    );

    assign p_fixed = p[M] ? as_sum : p;

`ifdef NRDIV_DZ_SHORTCUT_EN
    logic dz_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            p           <= '0;
            a_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
`ifdef NRDIV_DZ_SHORTCUT_EN
            dz_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        d_reg      <= bus.divisor;
                        a_reg      <= bus.dividend;
                        p          <= '0;
                        count      <= '0;
`ifdef NRDIV_DZ_SHORTCUT_EN
                        // Zero divisor: publish the same answer the full run would give.
                        if (bus.divisor == '0) begin
                            quo_q       <= '1;
                            rem_q       <= bus.dividend;
                            dz_q        <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    p     <= as_sum;
                    // Quotient bit is 1 when the new remainder is non-negative.
                    a_reg <= {a_reg[M-2:0], ~as_sum[M]};
                    count <= count + 1'b1;
                    if (count == CW'(M - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p           <= p_fixed;
                    quo_q       <= a_reg;
                    rem_q       <= p_fixed[M-1:0];
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef NRDIV_DZ_SHORTCUT_EN
                        dz_q        <= 1'b0;
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
`ifdef NRDIV_DZ_SHORTCUT_EN
    assign bus.dz        = dz_q;
`else
    assign bus.dz        = 1'b0;
`endif

endmodule

// File: tb/tb_non_restoring_divider.sv
// Purpose: self-checking bench for non_restoring_divider (M=8 directed/random, M=32 back-to-back).
// Latency: reference model is plain integer / and %, latency expectations derived from the operation timeline.
// Backpressure: exercises held results (out_ready low) and ignored in_valid outside IDLE.
module tb_non_restoring_divider;

`ifdef NRDIV_DZ_SHORTCUT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    nrdiv_if #(.M(8))  if8  ();
    nrdiv_if #(.M(32)) if32 ();

    non_restoring_divider #(.M(8)) u_div8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    non_restoring_divider #(.M(32)) u_div32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_q8(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return 8'hFF;
        return a / b;
    endfunction

    function automatic logic [7:0] ref_r8(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return a;
        return a % b;
    endfunction

    // Clocks from the accept edge to the edge that first samples out_valid high.
    function automatic int ref_lat8(input logic [7:0] b);
        if (DZ_EN && b == 8'd0) return 1;
        return 8 + 2;
    endfunction

    function automatic logic ref_dz(input logic [7:0] b);
        return DZ_EN && (b == 8'd0);
    endfunction

    // ---------------- drivers (observe only, no checking) ----------------
    task automatic run_div8(input logic [7:0] a, input logic [7:0] b, output int lat,
                            output logic [7:0] q, output logic [7:0] r, output logic d,
                            output bit tmo);
        int w;
        tmo = 1'b0;
        lat = 0;
        w = 0;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.dividend = a;
        if8.divisor  = b;
        while (!if8.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!if8.in_ready) tmo = 1'b1;
        @(posedge clk);
        #1;
        // Operands must have been captured at the accept edge only.
        if8.in_valid = 1'b0;
        if8.dividend = 8'($urandom);
        if8.divisor  = 8'($urandom);
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (if8.out_valid) break;
        end
        if (!if8.out_valid) tmo = 1'b1;
        q = if8.quotient;
        r = if8.remainder;
        d = if8.dz;
    endtask

    task automatic release8();
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b expected 1", if8.in_ready); end
        checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", if8.out_valid); end
        checks++; if (if8.quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient8: got %0d expected 0", if8.quotient); end
        checks++; if (if8.remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder8: got %0d expected 0", if8.remainder); end
        checks++; if (if8.dz !== 1'b0) begin errors++; $display("FAIL reset_dz8: got %b expected 0", if8.dz); end
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready32: got %b expected 1", if32.in_ready); end
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b expected 0", if32.out_valid); end
        checks++; if (if32.quotient !== 32'd0 || if32.remainder !== 32'd0) begin
            errors++; $display("FAIL reset_result32: got q=%0d r=%0d expected 0 0", if32.quotient, if32.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divide();
        logic [7:0] ta [10];
        logic [7:0] tb_ [10];
        ta  = '{8'd100, 8'd255, 8'd5, 8'd255, 8'd0, 8'd128, 8'd1, 8'd254, 8'd0, 8'd0};
        tb_ = '{8'd7,   8'd1,   8'd9, 8'd255, 8'd3, 8'd2,   8'd255, 8'd127, 8'd0, 8'd0};
        for (int i = 0; i < 14; i++) begin
            logic [7:0] a, b, q, r;
            logic d;
            int lat;
            bit tmo;
            if (i < 8) begin
                a = ta[i];
                b = tb_[i];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom_range(1, 255));
            end
            run_div8(a, b, lat, q, r, d, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL div8_timeout %0d/%0d: got timeout expected result", a, b); end
            checks++; if (q !== ref_q8(a, b)) begin errors++; $display("FAIL div8_q %0d/%0d: got %0d expected %0d", a, b, q, ref_q8(a, b)); end
            checks++; if (r !== ref_r8(a, b)) begin errors++; $display("FAIL div8_r %0d/%0d: got %0d expected %0d", a, b, r, ref_r8(a, b)); end
            checks++; if (d !== 1'b0) begin errors++; $display("FAIL div8_dz %0d/%0d: got %b expected 0", a, b, d); end
            checks++; if (lat != ref_lat8(b)) begin errors++; $display("FAIL div8_latency %0d/%0d: got %0d expected %0d", a, b, lat, ref_lat8(b)); end
            release8();
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r;
        logic d;
        int lat;
        bit tmo;
        run_div8(8'd200, 8'd0, lat, q, r, d, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL dz_timeout: got timeout expected result"); end
        checks++; if (q !== 8'd255) begin errors++; $display("FAIL dz_q: got %0d expected 255", q); end
        checks++; if (r !== 8'd200) begin errors++; $display("FAIL dz_r: got %0d expected 200", r); end
        checks++; if (d !== ref_dz(8'd0)) begin errors++; $display("FAIL dz_flag: got %b expected %b", d, ref_dz(8'd0)); end
        checks++; if (lat != ref_lat8(8'd0)) begin errors++; $display("FAIL dz_latency: got %0d expected %0d", lat, ref_lat8(8'd0)); end
        release8();
        @(negedge clk);
        checks++; if (if8.dz !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", if8.dz); end
    endtask

    task automatic test_hold();
        logic [7:0] q, r;
        logic d;
        int lat;
        bit tmo;
        bit bad;
        run_div8(8'd77, 8'd5, lat, q, r, d, tmo);
        checks++; if (tmo || q !== 8'd15 || r !== 8'd2) begin
            errors++; $display("FAIL hold_result: got q=%0d r=%0d tmo=%0d expected 15 2 0", q, r, tmo);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if8.in_valid = 1'b1;
            if8.dividend = 8'd9;
            if8.divisor  = 8'd3;
            if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 ||
                if8.quotient !== 8'd15 || if8.remainder !== 8'd2) bad = 1'b1;
        end
        checks++; if (bad) begin
            errors++; $display("FAIL hold_stable: got v=%b rdy=%b q=%0d r=%0d expected 1 0 15 2",
                               if8.out_valid, if8.in_ready, if8.quotient, if8.remainder);
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
        release8();
        @(negedge clk);
        checks++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_transfer: got v=%b rdy=%b expected 0 1", if8.out_valid, if8.in_ready);
        end
        repeat (3) @(negedge clk);
        checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_ignored_input: got rdy=%b v=%b expected 1 0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q, r;
        logic d;
        int lat;
        bit tmo;
        bit pulse;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.dividend = 8'd100;
        if8.divisor  = 8'd7;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_handshake: got rdy=%b v=%b expected 1 0", if8.in_ready, if8.out_valid);
        end
        checks++; if (if8.quotient !== 8'd0 || if8.remainder !== 8'd0 || if8.dz !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got q=%0d r=%0d dz=%b expected 0 0 0", if8.quotient, if8.remainder, if8.dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (if8.out_valid !== 1'b0) pulse = 1'b1;
        end
        checks++; if (pulse) begin errors++; $display("FAIL midreset_no_pulse: got out_valid pulse expected none"); end
        run_div8(8'd100, 8'd7, lat, q, r, d, tmo);
        checks++; if (tmo || q !== 8'd14 || r !== 8'd2) begin
            errors++; $display("FAIL midreset_next_div: got q=%0d r=%0d tmo=%0d expected 14 2 0", q, r, tmo);
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL midreset_latency: got %0d expected 10", lat); end
        release8();
    endtask

    localparam int NB = 16;
    logic [63:0] pend_q[$];
    int          acc_cyc[$];

    task automatic test_back_to_back();
        pend_q.delete();
        acc_cyc.delete();
        if32.out_ready = 1'b1;
        fork
            begin : producer
                for (int i = 0; i < NB; i++) begin
                    logic [31:0] a, b;
                    int w;
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                    if (b == 32'd0) b = 32'd1;
                    w = 0;
                    @(negedge clk);
                    if32.in_valid = 1'b1;
                    if32.dividend = a;
                    if32.divisor  = b;
                    while (!if32.in_ready && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!if32.in_ready) begin
                        errors++; checks++;
                        $display("FAIL b2b_accept_timeout %0d: got in_ready=0 expected 1", i);
                        break;
                    end
                    @(posedge clk);
                    #1;
                    acc_cyc.push_back(cyc);
                    pend_q.push_back({a, b});
                end
                if32.in_valid = 1'b0;
            end
            begin : consumer
                int got, wd;
                got = 0;
                wd = 0;
                while (got < NB && wd < NB * 60) begin
                    @(negedge clk);
                    wd++;
                    if (if32.out_valid) begin
                        logic [31:0] a, b, q, r;
                        logic [63:0] recon;
                        q = if32.quotient;
                        r = if32.remainder;
                        checks++;
                        if (pend_q.size() == 0) begin
                            errors++; $display("FAIL b2b_spurious: got result q=%0d expected none", q);
                        end else begin
                            {a, b} = pend_q.pop_front();
                            recon = 64'(q) * 64'(b) + 64'(r);
                            if (q !== a / b) begin errors++; $display("FAIL b2b_q %0d/%0d: got %0d expected %0d", a, b, q, a / b); end
                            checks++; if (r !== a % b) begin errors++; $display("FAIL b2b_r %0d/%0d: got %0d expected %0d", a, b, r, a % b); end
                            checks++; if (recon !== 64'(a) || !(r < b)) begin
                                errors++; $display("FAIL b2b_identity %0d/%0d: got q*d+r=%0d r=%0d expected %0d r<d", a, b, recon, r, a);
                            end
                            checks++; if (if32.dz !== 1'b0) begin errors++; $display("FAIL b2b_dz: got %b expected 0", if32.dz); end
                        end
                        got++;
                    end
                end
                checks++; if (got != NB) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got, NB); end
            end
        join
        if32.out_ready = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 32 + 3) begin
                errors++; $display("FAIL b2b_interval %0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], 35);
            end
        end
    endtask

    initial begin
        if8.in_valid   = 1'b0;
        if8.dividend   = '0;
        if8.divisor    = '0;
        if8.out_ready  = 1'b0;
        if32.in_valid  = 1'b0;
        if32.dividend  = '0;
        if32.divisor   = '0;
        if32.out_ready = 1'b0;
        test_reset();
        test_divide();
        test_div_zero();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
